mult_seq: RTL and testbench

MULT_SEQ -- requirements
Module: mult_seq

---
 rtl/mult_pkg.sv | 11 +
 rtl/mult_seq.sv | 93 +++++++++
 tb/tb_mult_seq.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared constants for the sequential multiplier: FSM state codes and the
// default operand width.
package mult_pkg;

  localparam int MULT_WIDTH_DEFAULT = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/mult_seq.sv
// Radix-2 shift-add multiplier, one partial product per clock, with
// sign/magnitude handling for two's-complement operands.
//
// state   | meaning
// IDLE    | waiting for start; product holds the last result
// RUN     | one shift-add step per cycle, counter counts WIDTH down to 0
// DONE    | product valid for one cycle; start here chains the next operation
module mult_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic               neg;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] shifted;

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

  // Magnitudes are plain WIDTH-bit unsigned, so the most negative value maps
  // onto 2^(WIDTH-1) without overflow.
  always_comb begin
    abs_a = multiplicand;
    abs_b = multiplier;
    if (is_signed && multiplicand[WIDTH-1]) abs_a = -multiplicand;
    if (is_signed && multiplier[WIDTH-1])   abs_b = -multiplier;
  end

  // The multiplier is consumed from lo[0] while the partial sum shifts into lo.
  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, mag_a} : {(WIDTH + 1){1'b0}});
    shifted = {sum, lo[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      mag_a   <= '0;
      hi      <= '0;
      lo      <= '0;
      neg     <= 1'b0;
      product <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            mag_a <= abs_a;
            hi    <= '0;
            lo    <= abs_b;
            neg   <= is_signed && (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
            cnt   <= CW'(WIDTH);
            state <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          hi  <= shifted[2*WIDTH-1:WIDTH];
          lo  <= shifted[WIDTH-1:0];
          cnt <= cnt - CW'(1);
          // product is only written on the last step so no partial sums leak out
          if (cnt == CW'(1)) begin
            state   <= ST_DONE;
            product <= neg ? -shifted : shifted;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq at WIDTH=32 and WIDTH=8 against an
// arithmetic reference model.
module tb_mult_seq;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic        start32 = 1'b0, sgn32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        busy32, done32;
  logic [63:0] product32;

  logic        start8 = 1'b0, sgn8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8;
  logic [15:0] product8;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mult_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .is_signed(sgn32),
    .multiplicand(a32), .multiplier(b32),
    .busy(busy32), .done(done32), .product(product32)
  );

  mult_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .is_signed(sgn8),
    .multiplicand(a8), .multiplier(b8),
    .busy(busy8), .done(done8), .product(product8)
  );

  function automatic logic [63:0] ref32(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [63:0] ea, eb;
    ea = s ? {{32{a[31]}}, a} : {32'b0, a};
    eb = s ? {{32{b[31]}}, b} : {32'b0, b};
    return ea * eb;
  endfunction

  function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic s);
    logic [15:0] ea, eb;
    ea = s ? {{8{a[7]}}, a} : {8'b0, a};
    eb = s ? {{8{b[7]}}, b} : {8'b0, b};
    return ea * eb;
  endfunction

  // Launches one operation and returns the result, the number of cycles
  // from the start edge to done (-1 on timeout) and the busy cycle count.
  task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic s, input bit no_wait,
                       output logic [63:0] p, output int lat, output int bcnt);
    if (!no_wait) @(negedge clk);
    a32 = a; b32 = b; sgn32 = s; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    lat = -1; bcnt = 0;
    for (int j = 0; j < 100; j++) begin
      if (done32) begin lat = j; break; end
      if (busy32) bcnt++;
      @(negedge clk);
    end
    p = product32;
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s,
                      output logic [15:0] p, output int lat);
    @(negedge clk);
    a8 = a; b8 = b; sgn8 = s; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = -1;
    for (int j = 0; j < 40; j++) begin
      if (done8) begin lat = j; break; end
      @(negedge clk);
    end
    p = product8;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy32 !== 1'b0 || done32 !== 1'b0 || product32 !== 64'd0) begin
      failures++;
      $display("FAIL reset32: busy=%b done=%b product=%h, want 0 0 0", busy32, done32, product32);
    end
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || product8 !== 16'd0) begin
      failures++;
      $display("FAIL reset8: busy=%b done=%b product=%h, want 0 0 0", busy8, done8, product8);
    end
    start32 = 1'b1; a32 = 32'd3; b32 = 32'd3;
    @(negedge clk);
    checks++;
    if (busy32 !== 1'b0) begin
      failures++;
      $display("FAIL reset_over_start: busy=%b, want 0", busy32);
    end
    start32 = 1'b0;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed;
    logic [31:0] ta [6];
    logic [31:0] tb [6];
    logic        ts [6];
    logic [63:0] p, want;
    int lat, bcnt;
    ta = '{32'd4, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,        32'h7FFF_FFFF};
    tb = '{32'd4, 32'd5,         32'hFFFF_FFFF, 32'h8000_0000, 32'hDEAD_BEEF, 32'h8000_0000};
    ts = '{1'b0,  1'b1,          1'b0,          1'b1,          1'b1,          1'b1};
    for (int i = 0; i < 6; i++) begin
      run32(ta[i], tb[i], ts[i], 1'b0, p, lat, bcnt);
      want = ref32(ta[i], tb[i], ts[i]);
      checks++;
      if (p !== want) begin
        failures++;
        $display("FAIL directed%0d product: got %h want %h", i, p, want);
      end
      checks++;
      if (lat != 32 || bcnt != 32) begin
        failures++;
        $display("FAIL directed%0d timing: done_at=%0d busy_cycles=%0d, want 32 32", i, lat, bcnt);
      end
    end
    checks++;
    if (ref32(32'd4, 32'd4, 1'b0) !== 64'd16 || ref32(32'hFFFF_FFFD, 32'd5, 1'b1) !== 64'hFFFF_FFFF_FFFF_FFF1) begin
      failures++;
      $display("FAIL model_sanity: reference model disagrees with known products");
    end
    @(negedge clk);
    checks++;
    if (done32 !== 1'b0 || busy32 !== 1'b0) begin
      failures++;
      $display("FAIL done_pulse_width: done=%b busy=%b after done cycle, want 0 0", done32, busy32);
    end
  endtask

  task automatic test_busy_ignore;
    logic [63:0] prev, want, p;
    int lat, bcnt, held_bad;
    run32(32'd7, 32'd9, 1'b0, 1'b0, prev, lat, bcnt);
    want = ref32(32'd123456, 32'hFFFF_FC00, 1'b1);
    @(negedge clk);
    a32 = 32'd123456; b32 = 32'hFFFF_FC00; sgn32 = 1'b1; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    lat = -1; held_bad = 0;
    for (int j = 0; j < 100; j++) begin
      if (done32) begin lat = j; break; end
      if (product32 !== prev) held_bad++;
      if (j == 5) begin start32 = 1'b1; a32 = $urandom; b32 = $urandom; sgn32 = 1'b0; end
      if (j == 6) start32 = 1'b0;
      @(negedge clk);
    end
    p = product32;
    checks++;
    if (held_bad != 0) begin
      failures++;
      $display("FAIL product_hold: product changed in %0d busy cycles, want 0 (held %h)", held_bad, prev);
    end
    checks++;
    if (p !== want) begin
      failures++;
      $display("FAIL busy_ignore product: got %h want %h", p, want);
    end
    checks++;
    if (lat != 32) begin
      failures++;
      $display("FAIL busy_ignore latency: got %0d want 32", lat);
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] p1, p2;
    int lat1, lat2, b1, b2;
    run32(32'd1000, 32'd3000, 1'b0, 1'b0, p1, lat1, b1);
    run32(32'hFFFF_FF00, 32'd77, 1'b1, 1'b1, p2, lat2, b2);
    checks++;
    if (p1 !== ref32(32'd1000, 32'd3000, 1'b0)) begin
      failures++;
      $display("FAIL b2b first product: got %h want %h", p1, ref32(32'd1000, 32'd3000, 1'b0));
    end
    checks++;
    if (p2 !== ref32(32'hFFFF_FF00, 32'd77, 1'b1)) begin
      failures++;
      $display("FAIL b2b second product: got %h want %h", p2, ref32(32'hFFFF_FF00, 32'd77, 1'b1));
    end
    checks++;
    if (lat2 + 1 != 33 || b2 != 32) begin
      failures++;
      $display("FAIL b2b spacing: done-to-done=%0d busy=%0d, want 33 32", lat2 + 1, b2);
    end
  endtask

  task automatic test_reset_mid;
    logic [63:0] p;
    int lat, bcnt, stray;
    @(negedge clk);
    a32 = 32'd55; b32 = 32'd66; sgn32 = 1'b0; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (busy32 !== 1'b0 || done32 !== 1'b0 || product32 !== 64'd0) begin
      failures++;
      $display("FAIL reset_mid: busy=%b done=%b product=%h, want 0 0 0", busy32, done32, product32);
    end
    stray = 0;
    for (int j = 0; j < 40; j++) begin
      if (done32 || busy32) stray++;
      @(negedge clk);
    end
    checks++;
    if (stray != 0) begin
      failures++;
      $display("FAIL reset_mid_stray: %0d active cycles after abort, want 0", stray);
    end
    run32(32'd12, 32'd11, 1'b0, 1'b0, p, lat, bcnt);
    checks++;
    if (p !== 64'd132 || lat != 32) begin
      failures++;
      $display("FAIL after_reset op: product=%h done_at=%0d, want 84 32", p, lat);
    end
  endtask

  task automatic test_random32;
    logic [31:0] a, b;
    logic s;
    logic [63:0] p, want;
    int lat, bcnt;
    for (int i = 0; i < 15; i++) begin
      a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
      run32(a, b, s, 1'b0, p, lat, bcnt);
      want = ref32(a, b, s);
      checks++;
      if (p !== want || lat != 32) begin
        failures++;
        $display("FAIL random32 a=%h b=%h s=%b: product=%h done_at=%0d, want %h 32", a, b, s, p, lat, want);
      end
    end
  endtask

  task automatic test_sweep8;
    logic [7:0] a, b;
    logic s;
    logic [15:0] p, want;
    int lat;
    for (int i = 0; i < 60; i++) begin
      a = 8'($urandom); b = 8'($urandom); s = 1'($urandom_range(0, 1));
      if (i == 0) begin a = 8'h80; b = 8'h80; s = 1'b1; end
      if (i == 1) begin a = 8'hFF; b = 8'hFF; s = 1'b0; end
      if (i == 2) begin a = 8'h00; b = 8'h9C; s = 1'b1; end
      run8(a, b, s, p, lat);
      want = ref8(a, b, s);
      checks++;
      if (p !== want || lat != 8) begin
        failures++;
        $display("FAIL sweep8 a=%h b=%h s=%b: product=%h done_at=%0d, want %h 8", a, b, s, p, lat, want);
      end
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_busy_ignore;
    test_back_to_back;
    test_reset_mid;
    test_random32;
    test_sweep8;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
